// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-stage trap sequencer.
// Captures ecall / mret / timer-interrupt events on a retirement boundary,
// waits for outstanding bus traffic to drain, then issues one-cycle
// trap or return pulses to the CSR file together with a pipeline flush
// and a fetch redirect. A settle cycle follows every pulse so that the
// CSR side effects (mstatus.MIE) are visible before itTime is sampled again.
module trap_ctrl #(
    parameter int ADDR_W    = 64,
    parameter int DRAIN_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid,
    input  logic [ADDR_W-1:0] commit_pc,
    input  logic [ADDR_W-1:0] commit_next_pc,
    input  logic              is_ecall,
    input  logic              is_mret,
    input  logic              itTime,
    input  logic [ADDR_W-1:0] irqAddr,
    input  logic [ADDR_W-1:0] mepc_i,
    input  logic              mem_busy,
    output logic [1:0]        IRQtype,
    output logic              IRQret,
    output logic [ADDR_W-1:0] retAddr,
    output logic              stall_commit,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              drain_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_TRAP   = 3'd2,
        ST_RET    = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_NONE  = 2'd0,
        K_ECALL = 2'd1,
        K_MRET  = 2'd2,
        K_INT   = 2'd3
    } kind_t;

    // Saturation limit of the 8-bit drain counter.
    localparam logic [7:0] DRAIN_MAX_C = 8'(DRAIN_MAX);

    // Encoding seen by the CSR file: 10 = ecall, 01 = timer interrupt.
    function automatic logic [1:0] irq_code(input kind_t kind);
        logic [1:0] code;
        case (kind)
            K_ECALL: code = 2'b10;
            K_INT:   code = 2'b01;
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    state_t              state_r;
    kind_t               kind_r;
    logic [ADDR_W-1:0]   epc_r;
    logic [7:0]          cnt_r;
    logic                drain_timeout_r;
    logic [1:0]          irq_type_r;
    logic                irq_ret_r;
    logic [ADDR_W-1:0]   ret_addr_r;
    logic                stall_r;
    logic                flush_r;
    logic                redirect_valid_r;

    logic                ev_valid_s;
    kind_t               ev_kind_s;
    logic [ADDR_W-1:0]   ev_epc_s;
    logic [ADDR_W-1:0]   redirect_pc_s;

    // Decode the retiring instruction into a trap event (ecall > mret > timer).
    always_comb begin
        ev_valid_s = 1'b0;
        ev_kind_s  = K_NONE;
        ev_epc_s   = '0;
        if (commit_valid) begin
            if (is_ecall) begin
                ev_valid_s = 1'b1;
                ev_kind_s  = K_ECALL;
                ev_epc_s   = commit_pc;
            end else if (is_mret) begin
                ev_valid_s = 1'b1;
                ev_kind_s  = K_MRET;
            end else if (itTime) begin
                // The retiring instruction completes, so resume after it.
                ev_valid_s = 1'b1;
                ev_kind_s  = K_INT;
                ev_epc_s   = commit_next_pc;
            end else begin
                ev_valid_s = 1'b0;
            end
        end else begin
            ev_valid_s = 1'b0;
        end
    end

    // Sequencer FSM with registered pulse/stall outputs and sticky drain timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= ST_IDLE;
            kind_r           <= K_NONE;
            epc_r            <= '0;
            cnt_r            <= 8'd0;
            drain_timeout_r  <= 1'b0;
            irq_type_r       <= 2'b00;
            irq_ret_r        <= 1'b0;
            ret_addr_r       <= '0;
            stall_r          <= 1'b0;
            flush_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
        end else begin
            irq_type_r       <= 2'b00;
            irq_ret_r        <= 1'b0;
            flush_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            stall_r          <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ev_valid_s) begin
                        kind_r  <= ev_kind_s;
                        epc_r   <= ev_epc_s;
                        stall_r <= 1'b1;
                        cnt_r   <= 8'd0;
                        if (mem_busy) begin
                            state_r <= ST_DRAIN;
                        end else if (ev_kind_s == K_MRET) begin
                            state_r          <= ST_RET;
                            irq_ret_r        <= 1'b1;
                            flush_r          <= 1'b1;
                            redirect_valid_r <= 1'b1;
                        end else begin
                            state_r          <= ST_TRAP;
                            irq_type_r       <= irq_code(ev_kind_s);
                            ret_addr_r       <= ev_epc_s;
                            flush_r          <= 1'b1;
                            redirect_valid_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    stall_r <= 1'b1;
                    if (mem_busy) begin
                        if (cnt_r < DRAIN_MAX_C) begin
                            cnt_r <= cnt_r + 8'd1;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                        // Flag the overlong drain but keep waiting for the bus.
                        if (cnt_r >= (DRAIN_MAX_C - 8'd1)) begin
                            drain_timeout_r <= 1'b1;
                        end else begin
                            drain_timeout_r <= drain_timeout_r;
                        end
                    end else begin
                        cnt_r <= 8'd0;
                        if (kind_r == K_MRET) begin
                            state_r          <= ST_RET;
                            irq_ret_r        <= 1'b1;
                            flush_r          <= 1'b1;
                            redirect_valid_r <= 1'b1;
                        end else begin
                            state_r          <= ST_TRAP;
                            irq_type_r       <= irq_code(kind_r);
                            ret_addr_r       <= epc_r;
                            flush_r          <= 1'b1;
                            redirect_valid_r <= 1'b1;
                        end
                    end
                end
                ST_TRAP, ST_RET: begin
                    state_r <= ST_SETTLE;
                    stall_r <= 1'b1;
                end
                ST_SETTLE: begin
                    state_r <= ST_IDLE;
                    kind_r  <= K_NONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Redirect target follows the live CSR values during the pulse cycle.
    always_comb begin
        redirect_pc_s = '0;
        case (state_r)
            ST_TRAP: redirect_pc_s = irqAddr;
            ST_RET:  redirect_pc_s = mepc_i;
            default: redirect_pc_s = '0;
        endcase
    end

    assign IRQtype        = irq_type_r;
    assign IRQret         = irq_ret_r;
    assign retAddr        = ret_addr_r;
    assign stall_commit   = stall_r;
    assign flush          = flush_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_s;
    assign drain_timeout  = drain_timeout_r;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed plus randomized checks of trap_ctrl against a
// transaction-level model: each accepted event expands into a list of
// expected per-cycle outputs (drain cycles, one pulse, one settle cycle).
module tb_trap_ctrl;

    localparam int AW   = 64;
    localparam int DMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          commit_valid;
    logic [AW-1:0] commit_pc;
    logic [AW-1:0] commit_next_pc;
    logic          is_ecall;
    logic          is_mret;
    logic          itTime;
    logic [AW-1:0] irqAddr;
    logic [AW-1:0] mepc_i;
    logic          mem_busy;
    logic [1:0]    IRQtype;
    logic          IRQret;
    logic [AW-1:0] retAddr;
    logic          stall_commit;
    logic          flush;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          drain_timeout;

    trap_ctrl #(.ADDR_W(AW), .DRAIN_MAX(DMAX)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_next_pc(commit_next_pc),
        .is_ecall(is_ecall), .is_mret(is_mret), .itTime(itTime),
        .irqAddr(irqAddr), .mepc_i(mepc_i), .mem_busy(mem_busy),
        .IRQtype(IRQtype), .IRQret(IRQret), .retAddr(retAddr),
        .stall_commit(stall_commit), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .drain_timeout(drain_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  irq_type;
        logic        irq_ret;
        logic [63:0] epc;
        logic        to_set;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_ret = 64'd0;
    logic        m_to = 1'b0;
    logic        m_idle = 1'b1;
    int          busy_left = 0;

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs for the current cycle against the model.
    task automatic check_outputs();
        exp_t        e;
        logic [1:0]  et  = 2'b00;
        logic        er  = 1'b0;
        logic        es  = 1'b0;
        logic [63:0] erp = 64'd0;
        if (q.size() > 0) begin
            e = q.pop_front();
            m_idle = 1'b0;
            es = 1'b1;
            et = e.irq_type;
            er = e.irq_ret;
            if (e.to_set) m_to = 1'b1;
            if (et != 2'b00) begin
                m_ret = e.epc;
                erp = irqAddr;
            end else if (er) begin
                erp = mepc_i;
            end
        end else begin
            m_idle = 1'b1;
        end
        chk("irq_type", 64'(IRQtype), 64'(et));
        chk("irq_ret", 64'(IRQret), 64'(er));
        chk("ret_addr", retAddr, m_ret);
        chk("stall", 64'(stall_commit), 64'(es));
        chk("flush", 64'(flush), 64'(et != 2'b00 || er));
        chk("redir_valid", 64'(redirect_valid), 64'(et != 2'b00 || er));
        chk("redir_pc", redirect_pc, erp);
        chk("drain_to", 64'(drain_timeout), 64'(m_to));
    endtask

    // Drive one cycle of inputs, update the model, clock, then check.
    // d = number of cycles mem_busy stays high starting at the event cycle.
    task automatic tick(input logic cv, input logic ec, input logic mr, input logic it,
                        input int d, input logic [63:0] pc, input logic [63:0] npc,
                        input logic [63:0] irq, input logic [63:0] mp);
        exp_t e;
        int   kind;
        commit_valid   = cv;
        is_ecall       = ec;
        is_mret        = mr;
        itTime         = it;
        commit_pc      = pc;
        commit_next_pc = npc;
        irqAddr        = irq;
        mepc_i         = mp;
        if (m_idle) begin
            kind = !cv ? 0 : ec ? 1 : mr ? 2 : it ? 3 : 0;
            if (kind != 0) begin
                mem_busy  = (d > 0);
                busy_left = (d > 0) ? d - 1 : 0;
                for (int i = 0; i < d; i++) begin
                    e.irq_type = 2'b00; e.irq_ret = 1'b0; e.epc = 64'd0;
                    e.to_set = ((d - 1) >= DMAX) && (i == DMAX);
                    q.push_back(e);
                end
                e.to_set  = 1'b0;
                e.irq_ret = (kind == 2);
                e.irq_type = (kind == 1) ? 2'b10 : (kind == 3) ? 2'b01 : 2'b00;
                e.epc = (kind == 1) ? pc : (kind == 3) ? npc : 64'd0;
                q.push_back(e);
                e.irq_type = 2'b00; e.irq_ret = 1'b0; e.epc = 64'd0;
                q.push_back(e);
            end else begin
                mem_busy = 1'($urandom_range(0, 1));
            end
        end else if (busy_left > 0) begin
            mem_busy = 1'b1;
            busy_left--;
        end else begin
            mem_busy = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_ticks(input int n, input logic it);
        for (int i = 0; i < n; i++)
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), it, 0,
                 rnd64(), rnd64(), rnd64(), rnd64());
    endtask

    initial begin
        rst = 1'b0;
        commit_valid = 1'b0; is_ecall = 1'b0; is_mret = 1'b0; itTime = 1'b0;
        commit_pc = '0; commit_next_pc = '0; irqAddr = '0; mepc_i = '0; mem_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        #2 rst = 1'b1;

        // ecall, no drain
        tick(1'b1, 1'b1, 1'b0, 1'b0, 0, 64'h8000_0010, 64'h8000_0014, 64'h8000_0100, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 64'h0, 64'h0, 64'h8000_0100, 64'h0);
        idle_ticks(2, 1'b0);
        // mret
        tick(1'b1, 1'b0, 1'b1, 1'b0, 0, 64'h8000_0020, 64'h8000_0024, 64'h8000_0100, 64'h8000_0014);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 64'h0, 64'h0, 64'h8000_0100, 64'h8000_0014);
        idle_ticks(2, 1'b0);
        // timer interrupt on a retirement, then itTime without retirement
        tick(1'b1, 1'b0, 1'b0, 1'b1, 0, 64'h8000_0200, 64'h8000_0204, 64'h8000_0100, 64'h0);
        idle_ticks(3, 1'b0);
        idle_ticks(4, 1'b1);
        // all three together: ecall wins; itTime still pending afterwards
        tick(1'b1, 1'b1, 1'b1, 1'b1, 0, 64'h8000_0300, 64'h8000_0304, 64'h8000_0100, 64'h8000_0500);
        idle_ticks(3, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 0, 64'h8000_0400, 64'h8000_0404, 64'h8000_0100, 64'h0);
        idle_ticks(3, 1'b0);
        // drain just short of the limit, then long enough to time out
        tick(1'b1, 1'b1, 1'b0, 1'b0, 4, 64'h8000_0600, 64'h8000_0604, rnd64(), rnd64());
        idle_ticks(7, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 5, 64'h8000_0700, 64'h8000_0704, rnd64(), rnd64());
        idle_ticks(10, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 2, rnd64(), rnd64(), rnd64(), rnd64());
        idle_ticks(6, 1'b0);

        // asynchronous reset in the middle of a drain
        tick(1'b1, 1'b1, 1'b0, 1'b0, 6, 64'h8000_0800, 64'h8000_0804, rnd64(), rnd64());
        idle_ticks(2, 1'b0);
        #2 rst = 1'b0;
        #1;
        q.delete();
        busy_left = 0;
        m_ret = 64'd0;
        m_to  = 1'b0;
        check_outputs();
        commit_valid = 1'b0; is_ecall = 1'b0; is_mret = 1'b0; itTime = 1'b0; mem_busy = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        idle_ticks(6, 1'b0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int d;
            d = ($urandom_range(0, 7) < 6) ? int'($urandom_range(0, 3)) : int'($urandom_range(5, 7));
            tick(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), d,
                 rnd64(), rnd64(), rnd64(), rnd64());
        end
        idle_ticks(12, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
